ts_slot_extract: RTL

Downstream stage of the TS slot inserter. Consumes its TS byte stream and SYNC marker and locates each frame header. Classifies the insertion slot as free or occupied. Extracts the occupied-slot payload as a valid-qualified byte stream toward the receive-side async FIFO, with per-frame status pulses and counters.

---
 rtl/ts_pkg.sv | 20 ++
 rtl/ts_frame_cnt.sv | 33 +++
 rtl/ts_slot_extract.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ts_pkg.sv
// Shared TS framing constants and FSM state encoding.
// Used by both the slot inserter and the slot extractor.
package ts_pkg;

   localparam int unsigned   WORD_SIZE_DEF   = 8;
   localparam int unsigned   PAYLOAD_LEN_DEF = 8;
   localparam logic [7:0]    HEAD_BYTE_DEF   = 8'hFF;
   localparam logic [7:0]    FREE_BYTE_DEF   = 8'hEE;
   localparam int unsigned   CNT_W_DEF       = 16;
   localparam int unsigned   PAY_CNT_W       = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ID,
      S_FLAG,
      S_PAY,
      S_SKIP
   } ts_state_e;

endpackage

// File: rtl/ts_frame_cnt.sv
// Frame/error counter pair: the frame count wraps, the error count saturates at all-ones.
module ts_frame_cnt #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             i_frm_inc,
   input  logic             i_err_inc,
   output logic [CNT_W-1:0] o_frm_cnt,
   output logic [CNT_W-1:0] o_err_cnt
);

   logic [CNT_W-1:0] r_frm;
   logic [CNT_W-1:0] r_err;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_frm <= '0;
         r_err <= '0;
      end else begin
         if (i_frm_inc) begin
            r_frm <= r_frm + CNT_W'(1);
         end
         if (i_err_inc && (r_err != '1)) begin
            r_err <= r_err + CNT_W'(1);
         end
      end
   end

   assign o_frm_cnt = r_frm;
   assign o_err_cnt = r_err;

endmodule

// File: rtl/ts_slot_extract.sv
// Locates TS frame headers, classifies the insertion slot and extracts occupied-slot payload
// as a valid-qualified byte stream with per-frame status pulses and counters.
module ts_slot_extract
   import ts_pkg::*;
#(
   parameter int unsigned           WORD_SIZE   = WORD_SIZE_DEF,
   parameter int unsigned           PAYLOAD_LEN = PAYLOAD_LEN_DEF,
   parameter logic [WORD_SIZE-1:0]  HEAD_BYTE   = HEAD_BYTE_DEF,
   parameter logic [WORD_SIZE-1:0]  FREE_BYTE   = FREE_BYTE_DEF,
   parameter int unsigned           CNT_W       = CNT_W_DEF
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 SYNC,
   input  logic [WORD_SIZE-1:0] TS_IN,
   output logic [WORD_SIZE-1:0] DOUT,
   output logic                 DOUT_VALID,
   output logic [WORD_SIZE-1:0] CH_ID,
   output logic                 SLOT_FREE,
   output logic                 FRAME_DONE,
   output logic                 FRAME_ERR,
   output logic [CNT_W-1:0]     FRM_CNT,
   output logic [CNT_W-1:0]     ERR_CNT
);

   localparam logic [PAY_CNT_W-1:0] CNT_LAST = PAY_CNT_W'(PAYLOAD_LEN - 1);

   ts_state_e            r_state, w_state_nxt;
   logic [PAY_CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [WORD_SIZE-1:0] r_dout, w_dout_nxt;
   logic [WORD_SIZE-1:0] r_ch_id, w_ch_id_nxt;
   logic                 r_valid, w_valid_nxt;
   logic                 r_free, w_free_nxt;
   logic                 r_done, w_done_nxt;
   logic                 r_err, w_err_nxt;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_dout  <= '0;
         r_ch_id <= '0;
         r_valid <= 1'b0;
         r_free  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dout  <= w_dout_nxt;
         r_ch_id <= w_ch_id_nxt;
         r_valid <= w_valid_nxt;
         r_free  <= w_free_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_dout_nxt  = r_dout;
      w_ch_id_nxt = r_ch_id;
      w_valid_nxt = 1'b0;
      w_free_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      // A header inside a frame aborts it; a valid header resynchronises immediately.
      if ((r_state != S_IDLE) && SYNC) begin
         w_err_nxt   = 1'b1;
         w_state_nxt = (TS_IN == HEAD_BYTE) ? S_ID : S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (SYNC) begin
                  if (TS_IN == HEAD_BYTE) begin
                     w_state_nxt = S_ID;
                  end else begin
                     w_err_nxt = 1'b1;
                  end
               end
            end
            S_ID: begin
               w_ch_id_nxt = TS_IN;
               w_state_nxt = S_FLAG;
            end
            S_FLAG: begin
               w_cnt_nxt = '0;
               if (TS_IN == FREE_BYTE) begin
                  w_free_nxt  = 1'b1;
                  w_state_nxt = S_SKIP;
               end else begin
                  w_state_nxt = S_PAY;
               end
            end
            S_PAY: begin
               w_dout_nxt  = TS_IN;
               w_valid_nxt = 1'b1;
               w_cnt_nxt   = r_cnt + PAY_CNT_W'(1);
               if (r_cnt == CNT_LAST) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            S_SKIP: begin
               w_cnt_nxt = r_cnt + PAY_CNT_W'(1);
               if (r_cnt == CNT_LAST) begin
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   ts_frame_cnt #(
      .CNT_W (CNT_W)
   ) u_frame_cnt (
      .CLK       (CLK),
      .RESET     (RESET),
      .i_frm_inc (w_done_nxt),
      .i_err_inc (w_err_nxt),
      .o_frm_cnt (FRM_CNT),
      .o_err_cnt (ERR_CNT)
   );

   assign DOUT       = r_dout;
   assign DOUT_VALID = r_valid;
   assign CH_ID      = r_ch_id;
   assign SLOT_FREE  = r_free;
   assign FRAME_DONE = r_done;
   assign FRAME_ERR  = r_err;

endmodule
